mem_access_ctrl: RTL and testbench

- Command-driven access controller sitting directly upstream of the 16x8 data memory bank; it is the only block that drives the memory's address, data and r_w lines.
- Accepts single load/store and block copy/fill commands from the CPU over a valid/ready handshake, sequences the level-sensitive memory safely, and returns a one-cycle response pulse.

---
 rtl/mem_access_ctrl_if.sv | 27 ++
 rtl/mem_access_ctrl.sv | 165 ++++++++++++++++
 tb/tb_mem_access_ctrl.sv | 323 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_access_ctrl_if.sv
// CPU-side command/response channel of the memory access controller.
// The master is the CPU. The slave is the controller.
interface mem_access_ctrl_if #(
  parameter int unsigned ADDR_W = 4,
  parameter int unsigned DATA_W = 8
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic [1:0]        cmd_op;
  logic [ADDR_W-1:0] cmd_addr;
  logic [ADDR_W-1:0] cmd_addr2;
  logic [4:0]        cmd_len;
  logic [DATA_W-1:0] cmd_wdata;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_data;
  logic              rsp_err;

  modport master (
    output cmd_valid, cmd_op, cmd_addr, cmd_addr2, cmd_len, cmd_wdata,
    input  cmd_ready, rsp_valid, rsp_data, rsp_err
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_addr, cmd_addr2, cmd_len, cmd_wdata,
    output cmd_ready, rsp_valid, rsp_data, rsp_err
  );
endinterface

// File: rtl/mem_access_ctrl.sv
// Sequences single load/store and block copy/fill commands onto the
// level-sensitive 16x8 data memory. Address and data never move while r_w is low.
module mem_access_ctrl #(
  parameter int unsigned ADDR_W   = 4,
  parameter int unsigned DATA_W   = 8,
  parameter int unsigned READ_LAT = 1   // legal 1..3
) (
  input  logic              clk,
  input  logic              reset,
  mem_access_ctrl_if.slave  bus,
  output logic              m_r_w,
  output logic [ADDR_W-1:0] m_raddr,
  output logic [ADDR_W-1:0] m_waddr,
  output logic [DATA_W-1:0] m_wdata,
  input  logic [DATA_W-1:0] m_rdata
);

  localparam int unsigned LEN_W = 5;
  localparam int unsigned LAT_W = 2;
  localparam int unsigned DEPTH = 2 ** ADDR_W;

  typedef enum logic [1:0] {
    OP_LOAD  = 2'b00,
    OP_STORE = 2'b01,
    OP_COPY  = 2'b10,
    OP_FILL  = 2'b11
  } op_e;

  typedef enum logic [2:0] {
    IDLE,
    RD_WAIT,
    WR_SET,
    WR_STB,
    DONE
  } state_e;

  state_e            state;
  op_e               op_q;
  logic [ADDR_W-1:0] src_q;
  logic [ADDR_W-1:0] dst_q;
  logic [LEN_W-1:0]  len_q;
  logic [LEN_W-1:0]  idx_q;
  logic [LAT_W-1:0]  lat_q;
  logic [LEN_W-1:0]  idx_nxt_c;
  op_e               cmd_op_c;

  assign idx_nxt_c = idx_q + LEN_W'(1);
  assign cmd_op_c  = op_e'(bus.cmd_op);

  // Single-process FSM; every output is set on the edge entering the state it belongs to.
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      op_q          <= OP_LOAD;
      src_q         <= '0;
      dst_q         <= '0;
      len_q         <= '0;
      idx_q         <= '0;
      lat_q         <= '0;
      m_r_w         <= 1'b1;
      m_raddr       <= '0;
      m_waddr       <= '0;
      m_wdata       <= '0;
      bus.cmd_ready <= 1'b0;
      bus.rsp_valid <= 1'b0;
      bus.rsp_data  <= '0;
      bus.rsp_err   <= 1'b0;
    end else begin
      bus.rsp_valid <= 1'b0;
      unique case (state)
        IDLE: begin
          bus.cmd_ready <= 1'b1;
          if (bus.cmd_valid && bus.cmd_ready) begin
            bus.cmd_ready <= 1'b0;
            op_q          <= cmd_op_c;
            src_q         <= bus.cmd_addr;
            dst_q         <= bus.cmd_addr2;
            len_q         <= bus.cmd_len;
            idx_q         <= '0;
            lat_q         <= '0;
            unique case (cmd_op_c)
              OP_LOAD: begin
                m_raddr <= bus.cmd_addr;
                state   <= RD_WAIT;
              end
              OP_STORE: begin
                m_waddr <= bus.cmd_addr;
                m_wdata <= bus.cmd_wdata;
                state   <= WR_SET;
              end
              default: begin
                // Block ops: zero length completes cleanly, oversize is rejected untouched.
                if ((bus.cmd_len == '0) || (bus.cmd_len > LEN_W'(DEPTH))) begin
                  bus.rsp_valid <= 1'b1;
                  bus.rsp_data  <= '0;
                  bus.rsp_err   <= (bus.cmd_len != '0);
                  state         <= DONE;
                end else if (cmd_op_c == OP_COPY) begin
                  m_raddr <= bus.cmd_addr;
                  state   <= RD_WAIT;
                end else begin
                  m_waddr <= bus.cmd_addr;
                  m_wdata <= bus.cmd_wdata;
                  state   <= WR_SET;
                end
              end
            endcase
          end
        end

        RD_WAIT: begin
          if (lat_q == LAT_W'(READ_LAT - 1)) begin
            if (op_q == OP_LOAD) begin
              bus.rsp_valid <= 1'b1;
              bus.rsp_data  <= m_rdata;
              bus.rsp_err   <= 1'b0;
              state         <= DONE;
            end else begin
              m_waddr <= dst_q + ADDR_W'(idx_q);
              m_wdata <= m_rdata;
              state   <= WR_SET;
            end
          end else begin
            lat_q <= lat_q + LAT_W'(1);
          end
        end

        WR_SET: begin
          m_r_w <= 1'b0;
          state <= WR_STB;
        end

        WR_STB: begin
          m_r_w <= 1'b1;
          idx_q <= idx_nxt_c;
          if ((op_q == OP_STORE) || (idx_nxt_c == len_q)) begin
            bus.rsp_valid <= 1'b1;
            bus.rsp_data  <= '0;
            bus.rsp_err   <= 1'b0;
            state         <= DONE;
          end else if (op_q == OP_COPY) begin
            // Next source byte is read only after the previous write finished,
            // so overlapping dst>src regions replicate source data.
            m_raddr <= src_q + ADDR_W'(idx_nxt_c);
            lat_q   <= '0;
            state   <= RD_WAIT;
          end else begin
            m_waddr <= src_q + ADDR_W'(idx_nxt_c);
            state   <= WR_SET;
          end
        end

        DONE: begin
          bus.cmd_ready <= 1'b1;
          state         <= IDLE;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench: three controllers (READ_LAT 1,2,3) each attached to its own
// 16x8 level-sensitive memory model.
module tb_mem_access_ctrl;

  localparam int unsigned N = 3;

  logic clk;
  logic reset;

  logic [N-1:0]       cmd_valid;
  logic [N-1:0]       cmd_ready;
  logic [N-1:0][1:0]  cmd_op;
  logic [N-1:0][3:0]  cmd_addr;
  logic [N-1:0][3:0]  cmd_addr2;
  logic [N-1:0][4:0]  cmd_len;
  logic [N-1:0][7:0]  cmd_wdata;
  logic [N-1:0]       rsp_valid;
  logic [N-1:0][7:0]  rsp_data;
  logic [N-1:0]       rsp_err;
  logic [N-1:0]       m_r_w;
  logic [N-1:0][3:0]  m_raddr;
  logic [N-1:0][3:0]  m_waddr;
  logic [N-1:0][7:0]  m_wdata;
  logic [N-1:0][7:0]  m_rdata;

  logic [7:0] mem [N][16];
  int         wr_cnt [N];
  int         cyc;
  int         n_checks;
  int         n_fail;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Memory model: written while r_w is low, read combinationally.
  always @(posedge clk) begin
    for (int k = 0; k < N; k++) begin
      if (m_r_w[k] === 1'b0) begin
        mem[k][m_waddr[k]] <= m_wdata[k];
        wr_cnt[k]          <= wr_cnt[k] + 1;
      end
    end
  end

  for (genvar g = 0; g < N; g++) begin : g_dut
    mem_access_ctrl_if #(.ADDR_W(4), .DATA_W(8)) bus ();
    assign bus.cmd_valid = cmd_valid[g];
    assign bus.cmd_op    = cmd_op[g];
    assign bus.cmd_addr  = cmd_addr[g];
    assign bus.cmd_addr2 = cmd_addr2[g];
    assign bus.cmd_len   = cmd_len[g];
    assign bus.cmd_wdata = cmd_wdata[g];
    assign cmd_ready[g]  = bus.cmd_ready;
    assign rsp_valid[g]  = bus.rsp_valid;
    assign rsp_data[g]   = bus.rsp_data;
    assign rsp_err[g]    = bus.rsp_err;
    assign m_rdata[g]    = mem[g][m_raddr[g]];

    mem_access_ctrl #(.ADDR_W(4), .DATA_W(8), .READ_LAT(g + 1)) dut (
      .clk     (clk),
      .reset   (reset),
      .bus     (bus.slave),
      .m_r_w   (m_r_w[g]),
      .m_raddr (m_raddr[g]),
      .m_waddr (m_waddr[g]),
      .m_wdata (m_wdata[g]),
      .m_rdata (m_rdata[g])
    );
  end

  // Present a command and return the cycle count just after the accepting edge.
  task automatic send_cmd(input int k, input logic [1:0] op, input logic [3:0] a,
                          input logic [3:0] a2, input logic [4:0] len,
                          input logic [7:0] wd, output int c0);
    @(negedge clk);
    cmd_op[k] = op; cmd_addr[k] = a; cmd_addr2[k] = a2;
    cmd_len[k] = len; cmd_wdata[k] = wd; cmd_valid[k] = 1'b1;
    c0 = -1;
    for (int i = 0; i < 100; i++) begin
      if (cmd_ready[k] === 1'b1) begin
        @(posedge clk);
        #1;
        cmd_valid[k] = 1'b0;
        c0 = cyc;
        return;
      end
      @(negedge clk);
    end
    cmd_valid[k] = 1'b0;
    n_checks++; n_fail++;
    $display("FAIL accept_timeout: inst %0d never raised cmd_ready, required within 100 cycles", k);
  endtask

  // Latency of the response pulse in cycles counted from the accepting edge (-1 on timeout).
  task automatic wait_rsp(input int k, input int c0, output int lat);
    lat = -1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (rsp_valid[k] === 1'b1) begin
        lat = cyc - c0 + 1;
        return;
      end
    end
  endtask

  task automatic do_store(input int k, input logic [3:0] a, input logic [7:0] d);
    int c0, lat;
    send_cmd(k, 2'b01, a, 4'd0, 5'd0, d, c0);
    wait_rsp(k, c0, lat);
  endtask

  task automatic test_reset;
    reset = 1'b1;
    cmd_valid = '0;
    repeat (2) @(negedge clk);
    for (int k = 0; k < N; k++) begin
      n_checks++;
      if ({m_r_w[k], m_raddr[k], m_waddr[k], m_wdata[k], rsp_valid[k], rsp_data[k],
           rsp_err[k], cmd_ready[k]} !== {1'b1, 4'd0, 4'd0, 8'd0, 1'b0, 8'd0, 1'b0, 1'b0}) begin
        n_fail++;
        $display("FAIL reset_values inst %0d: got r_w=%b ra=%h wa=%h wd=%h rv=%b rd=%h re=%b rdy=%b, expected r_w=1 others 0",
                 k, m_r_w[k], m_raddr[k], m_waddr[k], m_wdata[k], rsp_valid[k], rsp_data[k],
                 rsp_err[k], cmd_ready[k]);
      end
    end
    reset = 1'b0;
    @(negedge clk);
    n_checks++;
    if (cmd_ready !== 3'b111) begin
      n_fail++;
      $display("FAIL reset_release_ready: got %b expected 111", cmd_ready);
    end
  endtask

  task automatic test_store_load;
    int c0, lat, w0;
    w0 = wr_cnt[0];
    send_cmd(0, 2'b01, 4'd3, 4'd0, 5'd0, 8'hA5, c0);
    wait_rsp(0, c0, lat);
    n_checks++;
    if (lat !== 3) begin n_fail++; $display("FAIL store_latency: got %0d expected 3", lat); end
    n_checks++;
    if ({rsp_data[0], rsp_err[0]} !== 9'h000) begin
      n_fail++; $display("FAIL store_rsp: got data=%h err=%b expected 00/0", rsp_data[0], rsp_err[0]);
    end
    n_checks++;
    if (wr_cnt[0] - w0 !== 1) begin
      n_fail++; $display("FAIL store_strobes: got %0d expected 1", wr_cnt[0] - w0);
    end
    n_checks++;
    if (mem[0][3] !== 8'hA5) begin n_fail++; $display("FAIL store_mem3: got %h expected a5", mem[0][3]); end

    send_cmd(0, 2'b00, 4'd3, 4'd0, 5'd0, 8'h00, c0);
    wait_rsp(0, c0, lat);
    n_checks++;
    if (lat !== 2) begin n_fail++; $display("FAIL load_latency: got %0d expected 2", lat); end
    n_checks++;
    if (rsp_data[0] !== 8'hA5) begin n_fail++; $display("FAIL load_data: got %h expected a5", rsp_data[0]); end
    @(negedge clk);
    n_checks++;
    if ({rsp_valid[0], rsp_data[0]} !== {1'b0, 8'hA5}) begin
      n_fail++; $display("FAIL load_hold: got valid=%b data=%h expected 0/a5", rsp_valid[0], rsp_data[0]);
    end
  endtask

  task automatic test_fill_wrap;
    int c0, lat, w0;
    do_store(0, 4'd2, 8'h5A);
    w0 = wr_cnt[0];
    send_cmd(0, 2'b11, 4'd14, 4'd0, 5'd4, 8'h3C, c0);
    wait_rsp(0, c0, lat);
    n_checks++;
    if (lat !== 9) begin n_fail++; $display("FAIL fill_latency: got %0d expected 9", lat); end
    n_checks++;
    if (wr_cnt[0] - w0 !== 4) begin
      n_fail++; $display("FAIL fill_strobes: got %0d expected 4", wr_cnt[0] - w0);
    end
    n_checks++;
    if ({mem[0][14], mem[0][15], mem[0][0], mem[0][1], mem[0][2], mem[0][3]} !== 48'h3C3C3C3C5AA5) begin
      n_fail++;
      $display("FAIL fill_mem: got %h %h %h %h %h %h expected 3c 3c 3c 3c 5a a5",
               mem[0][14], mem[0][15], mem[0][0], mem[0][1], mem[0][2], mem[0][3]);
    end
  endtask

  task automatic test_copy;
    int c0, lat, w0;
    for (int k = 0; k < N; k++) begin
      do_store(k, 4'd0, 8'h11);
      do_store(k, 4'd1, 8'h22);
      do_store(k, 4'd2, 8'h33);
      w0 = wr_cnt[k];
      send_cmd(k, 2'b10, 4'd0, 4'd8, 5'd3, 8'h00, c0);
      wait_rsp(k, c0, lat);
      n_checks++;
      if (lat !== 3 * (k + 3) + 1) begin
        n_fail++; $display("FAIL copy_latency inst %0d: got %0d expected %0d", k, lat, 3 * (k + 3) + 1);
      end
      n_checks++;
      if ({mem[k][8], mem[k][9], mem[k][10], rsp_err[k]} !== {24'h112233, 1'b0}) begin
        n_fail++;
        $display("FAIL copy_mem inst %0d: got %h %h %h err=%b expected 11 22 33 err=0",
                 k, mem[k][8], mem[k][9], mem[k][10], rsp_err[k]);
      end
      n_checks++;
      if (wr_cnt[k] - w0 !== 3) begin
        n_fail++; $display("FAIL copy_strobes inst %0d: got %0d expected 3", k, wr_cnt[k] - w0);
      end
    end
    // Overlapping copy dst=src+1 replicates the first byte.
    send_cmd(0, 2'b10, 4'd0, 4'd1, 5'd2, 8'h00, c0);
    wait_rsp(0, c0, lat);
    n_checks++;
    if ({lat[7:0], mem[0][0], mem[0][1], mem[0][2]} !== {8'd7, 24'h111111}) begin
      n_fail++;
      $display("FAIL copy_overlap: got lat=%0d mem=%h %h %h expected 7 11 11 11",
               lat, mem[0][0], mem[0][1], mem[0][2]);
    end
  endtask

  task automatic test_errors;
    int c0, lat, w0;
    w0 = wr_cnt[1];
    send_cmd(1, 2'b10, 4'd0, 4'd8, 5'd20, 8'h00, c0);
    wait_rsp(1, c0, lat);
    n_checks++;
    if ({lat[7:0], rsp_err[1]} !== {8'd1, 1'b1}) begin
      n_fail++; $display("FAIL err_len20: got lat=%0d err=%b expected 1/1", lat, rsp_err[1]);
    end
    send_cmd(1, 2'b11, 4'd5, 4'd0, 5'd0, 8'hEE, c0);
    wait_rsp(1, c0, lat);
    n_checks++;
    if ({lat[7:0], rsp_err[1]} !== {8'd1, 1'b0}) begin
      n_fail++; $display("FAIL fill_len0: got lat=%0d err=%b expected 1/0", lat, rsp_err[1]);
    end
    n_checks++;
    if (wr_cnt[1] - w0 !== 0) begin
      n_fail++; $display("FAIL err_no_write: got %0d strobes expected 0", wr_cnt[1] - w0);
    end
  endtask

  task automatic test_back_to_back;
    int c0, c1, lat;
    send_cmd(2, 2'b01, 4'd5, 4'd0, 5'd0, 8'h99, c0);
    cmd_op[2] = 2'b00; cmd_addr[2] = 4'd5; cmd_valid[2] = 1'b1;
    c1 = -1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (cmd_ready[2] === 1'b1) begin
        @(posedge clk);
        #1;
        c1 = cyc;
        cmd_valid[2] = 1'b0;
        break;
      end
    end
    cmd_valid[2] = 1'b0;
    n_checks++;
    if (c1 - c0 !== 4) begin n_fail++; $display("FAIL held_accept: got %0d cycles expected 4", c1 - c0); end
    wait_rsp(2, c1, lat);
    n_checks++;
    if ({lat[7:0], rsp_data[2]} !== {8'd4, 8'h99}) begin
      n_fail++; $display("FAIL held_load: got lat=%0d data=%h expected 4/99", lat, rsp_data[2]);
    end
  endtask

  task automatic test_abort;
    int c0, w0;
    logic saw_rsp;
    for (int a = 4; a < 8; a++) do_store(0, 4'(a), 8'h00);
    w0 = wr_cnt[0];
    saw_rsp = 1'b0;
    send_cmd(0, 2'b11, 4'd4, 4'd0, 5'd4, 8'hE1, c0);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      saw_rsp |= rsp_valid[0];
      if (cyc >= c0 + 2) break;
    end
    reset = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({m_r_w[0], rsp_valid[0], cmd_ready[0]} !== 3'b100) begin
      n_fail++;
      $display("FAIL abort_reset_out: got r_w=%b rv=%b rdy=%b expected 1 0 0", m_r_w[0], rsp_valid[0], cmd_ready[0]);
    end
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    n_checks++;
    if (cmd_ready[0] !== 1'b1) begin n_fail++; $display("FAIL abort_ready: got %b expected 1", cmd_ready[0]); end
    repeat (8) begin
      @(negedge clk);
      saw_rsp |= rsp_valid[0];
    end
    n_checks++;
    if (saw_rsp !== 1'b0) begin n_fail++; $display("FAIL abort_no_rsp: got rsp_valid pulse expected none"); end
    n_checks++;
    if ({wr_cnt[0] - w0 == 1, mem[0][4], mem[0][5], mem[0][6], mem[0][7]} !== {1'b1, 32'hE1000000}) begin
      n_fail++;
      $display("FAIL abort_mem: got strobes=%0d mem=%h %h %h %h expected 1 e1 00 00 00",
               wr_cnt[0] - w0, mem[0][4], mem[0][5], mem[0][6], mem[0][7]);
    end
  endtask

  initial begin
    cmd_valid = '0; cmd_op = '0; cmd_addr = '0; cmd_addr2 = '0; cmd_len = '0; cmd_wdata = '0;
    reset = 1'b1;
    n_checks = 0;
    n_fail = 0;
    test_reset();
    test_store_load();
    test_fill_wrap();
    test_copy();
    test_errors();
    test_back_to_back();
    test_abort();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
